// File: rtl/baud_pkg.sv
// Shared definitions for the fractional baud generator:
// rate encodings, standard baud values and the divisor helper.
package baud_pkg;

  typedef enum logic [1:0] {
    RATE_9600   = 2'b00,
    RATE_19200  = 2'b01,
    RATE_57600  = 2'b10,
    RATE_115200 = 2'b11
  } rate_t;

  localparam int BAUD_9600   = 9600;
  localparam int BAUD_19200  = 19200;
  localparam int BAUD_57600  = 57600;
  localparam int BAUD_115200 = 115200;

  typedef struct packed {
    logic [31:0] whole;
    logic [31:0] frac;
  } div_t;

  // Clocks per oversample tick as {int, frac};
  // frac = floor(rem * 2^frac_w / (baud * os)).
  function automatic div_t baud_div(
    input int clk_hz,
    input int baud,
    input int os,
    input int frac_w
  );
    longint den;
    longint q;
    longint r;
    longint f;
    div_t   d;
    den     = longint'(baud) * longint'(os);
    q       = longint'(clk_hz) / den;
    r       = longint'(clk_hz) - q * den;
    f       = (r << frac_w) / den;
    d.whole = q[31:0];
    d.frac  = f[31:0];
    return d;
  endfunction

endpackage

// File: rtl/baud_gen_frac_divider.sv
// frac_divider: period counter, fraction accumulator and
// divisor shadow; emits the registered os_tick strobe.
// Ports: clk, rst (async high), en, src_int/src_frac (divisor
// source), os_tick (registered), boundary (comb, last cycle).
// Fraction logic present only when BAUD_FRAC_EN is defined.
module frac_divider
  import baud_pkg::*;
#(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DIV_W-1:0]  src_int,
  input  logic [FRAC_W-1:0] src_frac,
  output logic              os_tick,
  output logic              boundary
);

  logic             run;
  logic             start;
  logic             carry;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] sh_int;
  logic [DIV_W-1:0] n_eff;
  logic [DIV_W:0]   last;

  assign start = en && !run;

  // Divisors 0 and 1 are clamped to 2.
  assign n_eff = (sh_int < DIV_W'(2)) ? DIV_W'(2) : sh_int;

  assign last = {1'b0, n_eff} - (DIV_W+1)'(1)
              + (DIV_W+1)'(carry);

  assign boundary = en && run && ({1'b0, cnt} == last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run     <= 1'b0;
      cnt     <= '0;
      sh_int  <= DIV_W'(2);
      os_tick <= 1'b0;
    end else if (!en) begin
      run     <= 1'b0;
      cnt     <= '0;
      os_tick <= 1'b0;
    end else if (start) begin
      run     <= 1'b1;
      cnt     <= '0;
      sh_int  <= src_int;
      os_tick <= 1'b0;
    end else if (boundary) begin
      cnt     <= '0;
      sh_int  <= src_int;
      os_tick <= 1'b1;
    end else begin
      cnt     <= cnt + DIV_W'(1);
      os_tick <= 1'b0;
    end
  end

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc;

  // The fraction becoming active is added at the boundary
  // that loads it, so it needs no separate shadow copy;
  // its carry stretches the following period by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      carry <= 1'b0;
    end else if (!en || start) begin
      acc   <= '0;
      carry <= 1'b0;
    end else if (boundary) begin
      {carry, acc} <= {1'b0, acc} + {1'b0, src_frac};
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^src_frac;
  assign carry       = 1'b0;
`endif

endmodule

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: fractional baud generator with preset table,
// runtime divisor register, os_tick and bit_tick strobes.
// Ports: clk, rst (async high), en, rate_sel, use_custom,
// div_load, div_int, div_frac, os_tick, bit_tick.
// Define BAUD_FRAC_EN to enable the fractional accumulator.
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int CLK_HZ     = 20_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        rate_sel,
  input  logic              use_custom,
  input  logic              div_load,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              os_tick,
  output logic              bit_tick
);

  localparam int OS_W = $clog2(OVERSAMPLE);

  localparam div_t P0 =
    baud_div(CLK_HZ, BAUD_9600, OVERSAMPLE, FRAC_W);
  localparam div_t P1 =
    baud_div(CLK_HZ, BAUD_19200, OVERSAMPLE, FRAC_W);
  localparam div_t P2 =
    baud_div(CLK_HZ, BAUD_57600, OVERSAMPLE, FRAC_W);
  localparam div_t P3 =
    baud_div(CLK_HZ, BAUD_115200, OVERSAMPLE, FRAC_W);

  localparam logic [DIV_W-1:0]  P0_I = P0.whole[DIV_W-1:0];
  localparam logic [DIV_W-1:0]  P1_I = P1.whole[DIV_W-1:0];
  localparam logic [DIV_W-1:0]  P2_I = P2.whole[DIV_W-1:0];
  localparam logic [DIV_W-1:0]  P3_I = P3.whole[DIV_W-1:0];
  localparam logic [FRAC_W-1:0] P0_F = P0.frac[FRAC_W-1:0];
  localparam logic [FRAC_W-1:0] P1_F = P1.frac[FRAC_W-1:0];
  localparam logic [FRAC_W-1:0] P2_F = P2.frac[FRAC_W-1:0];
  localparam logic [FRAC_W-1:0] P3_F = P3.frac[FRAC_W-1:0];

  logic [DIV_W-1:0]  cust_int;
  logic [FRAC_W-1:0] cust_frac;
  logic [DIV_W-1:0]  pre_int;
  logic [FRAC_W-1:0] pre_frac;
  logic [DIV_W-1:0]  src_int;
  logic [FRAC_W-1:0] src_frac;
  logic [OS_W-1:0]   os_cnt;
  logic              boundary;

  always_comb begin
    pre_int  = P0_I;
    pre_frac = P0_F;
    unique case (rate_t'(rate_sel))
      RATE_9600:   begin pre_int = P0_I; pre_frac = P0_F; end
      RATE_19200:  begin pre_int = P1_I; pre_frac = P1_F; end
      RATE_57600:  begin pre_int = P2_I; pre_frac = P2_F; end
      RATE_115200: begin pre_int = P3_I; pre_frac = P3_F; end
    endcase
  end

  // A load coinciding with a boundary bypasses the register
  // so the shadow takes the freshly loaded value.
  always_comb begin
    src_int  = pre_int;
    src_frac = pre_frac;
    if (use_custom) begin
      src_int  = div_load ? div_int  : cust_int;
      src_frac = div_load ? div_frac : cust_frac;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cust_int  <= DIV_W'(2);
      cust_frac <= '0;
    end else if (div_load) begin
      cust_int  <= div_int;
      cust_frac <= div_frac;
    end
  end

  frac_divider #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .src_int  (src_int),
    .src_frac (src_frac),
    .os_tick  (os_tick),
    .boundary (boundary)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os_cnt   <= '0;
      bit_tick <= 1'b0;
    end else if (!en) begin
      os_cnt   <= '0;
      bit_tick <= 1'b0;
    end else if (boundary) begin
      if (os_cnt == OS_W'(OVERSAMPLE - 1)) begin
        os_cnt   <= '0;
        bit_tick <= 1'b1;
      end else begin
        os_cnt   <= os_cnt + OS_W'(1);
        bit_tick <= 1'b0;
      end
    end else begin
      bit_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Testbench for baud_gen_frac: table of divisor setups plus
// hand sequences; expected tick spacing kept in a scoreboard.
module tb_baud_gen_frac;

`ifdef BAUD_FRAC_EN
  localparam bit FR = 1'b1;
`else
  localparam bit FR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  rate_sel = 2'b00;
  logic        use_custom = 1'b0;
  logic        div_load = 1'b0;
  logic [15:0] div_int = 16'd0;
  logic [3:0]  div_frac = 4'd0;
  logic        os_tick;
  logic        bit_tick;

  baud_gen_frac #(
    .CLK_HZ     (20_000_000),
    .OVERSAMPLE (16),
    .DIV_W      (16),
    .FRAC_W     (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .rate_sel   (rate_sel),
    .use_custom (use_custom),
    .div_load   (div_load),
    .div_int    (div_int),
    .div_frac   (div_frac),
    .os_tick    (os_tick),
    .bit_tick   (bit_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    ticks;
    int    gap;
    int    bits;
  } exp_t;

  typedef struct {
    string      name;
    bit         cust;
    logic [1:0] rs;
    int         di;
    int         df;
    int         first;
    int         sum16;
  } vec_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last = 0;
  int   acc_n = 0;
  int   acc_g = 0;
  int   acc_b = 0;

  task automatic check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // Monitor: accumulate spacing of os_ticks and compare
  // against the record at the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (os_tick === 1'b1) begin
        acc_g += cyc - last;
        last = cyc;
        acc_n++;
        if (bit_tick === 1'b1) acc_b++;
        if (exp_q.size() > 0 && acc_n == exp_q[0].ticks) begin
          e = exp_q.pop_front();
          check({e.name, "_gap"}, acc_g, e.gap);
          check({e.name, "_bits"}, acc_b, e.bits);
          acc_n = 0;
          acc_g = 0;
          acc_b = 0;
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(string name, int t, int g, int b);
    exp_t e;
    e.name  = name;
    e.ticks = t;
    e.gap   = g;
    e.bits  = b;
    exp_q.push_back(e);
  endtask

  task automatic flush();
    exp_q.delete();
    acc_n = 0;
    acc_g = 0;
    acc_b = 0;
  endtask

  task automatic go();
    flush();
    en   = 1'b1;
    last = cyc + 1;
  endtask

  task automatic stop();
    en = 1'b0;
    step(2);
  endtask

  task automatic load(int i, int f);
    div_int  = 16'(i);
    div_frac = 4'(f);
    div_load = 1'b1;
    step(1);
    div_load = 1'b0;
  endtask

  task automatic drain(string name, int budget);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      step(1);
      k++;
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: %0d records left, want 0",
               name, exp_q.size());
      flush();
    end
  endtask

  task automatic wait_sig(string name, bit want_bit, int budget);
    int k;
    step(1);
    k = 1;
    while (k < budget &&
           !(want_bit ? bit_tick === 1'b1 : os_tick === 1'b1)) begin
      step(1);
      k++;
    end
    if (!(want_bit ? bit_tick === 1'b1 : os_tick === 1'b1)) begin
      tests++;
      fails++;
      $display("FAIL %s_wait: strobe absent after %0d, want 1",
               name, k);
    end
  endtask

  vec_t tbl[8];
  int   strobes;

  initial begin
    tbl[0] = '{"c4",    1'b1, 2'b00, 4, 0, 4,   64};
    tbl[1] = '{"c5f8",  1'b1, 2'b00, 5, 8, 5,   FR ? 88 : 80};
    tbl[2] = '{"p115k", 1'b0, 2'b11, 0, 0, 10,  FR ? 173 : 160};
    tbl[3] = '{"p9600", 1'b0, 2'b00, 0, 0, 130, FR ? 2083 : 2080};
    tbl[4] = '{"c0",    1'b1, 2'b00, 0, 0, 2,   32};
    tbl[5] = '{"c1",    1'b1, 2'b00, 1, 0, 2,   32};
    tbl[6] = '{"p57k",  1'b0, 2'b10, 0, 0, 21,  FR ? 347 : 336};
    tbl[7] = '{"c3f15", 1'b1, 2'b00, 3, 15, 3,  FR ? 63 : 48};

    #3;
    check("rst_os", int'(os_tick), 0);
    check("rst_bit", int'(bit_tick), 0);
    step(2);
    check("rst_hold_os", int'(os_tick), 0);
    rst = 1'b0;
    step(1);

    for (int i = 0; i < 8; i++) begin
      stop();
      use_custom = tbl[i].cust;
      rate_sel   = tbl[i].rs;
      if (tbl[i].cust) load(tbl[i].di, tbl[i].df);
      go();
      push({tbl[i].name, "_first"}, 1, tbl[i].first, 0);
      push({tbl[i].name, "_sum16"}, 16, tbl[i].sum16, 1);
      drain(tbl[i].name, 3000);
    end

    // Preset change mid-period: current period keeps old length.
    stop();
    use_custom = 1'b0;
    rate_sel   = 2'b11;
    go();
    push("sw_first", 1, 10, 0);
    push("sw_sum16", 16, FR ? 173 : 160, 1);
    drain("sw_run", 500);
    push("sw_old", 1, 10, 0);
    push("sw_new", 1, 65, 0);
    step(4);
    rate_sel = 2'b01;
    drain("sw_new", 300);

    // Runtime load: deferred to boundary, bypass on boundary.
    stop();
    use_custom = 1'b1;
    load(4, 0);
    go();
    push("ld_p1", 1, 4, 0);
    push("ld_p2", 1, 4, 0);
    push("ld_p3", 1, 7, 0);
    push("ld_p4", 1, 7, 0);
    push("ld_p5", 1, 3, 0);
    wait_sig("ld_t1", 1'b0, 20);
    step(1);
    load(7, 0);
    wait_sig("ld_t2", 1'b0, 20);
    wait_sig("ld_t3", 1'b0, 20);
    step(6);
    load(3, 0);
    drain("ld", 50);

    // Async reset while both strobes are high.
    wait_sig("rs_bit", 1'b1, 200);
    check("pre_rst_bit", int'(bit_tick), 1);
    rst = 1'b1;
    #1;
    check("async_rst_os", int'(os_tick), 0);
    check("async_rst_bit", int'(bit_tick), 0);
    #4;
    rst = 1'b0;
    flush();
    last = cyc + 1;
    push("rs_first", 1, 2, 0);
    push("rs_sum16", 16, 32, 1);
    drain("rs", 100);

    // Enable dropped mid-period, then restarted.
    load(4, 0);
    wait_sig("en_t1", 1'b0, 20);
    wait_sig("en_t2", 1'b0, 20);
    step(2);
    en = 1'b0;
    strobes = 0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      if (os_tick === 1'b1 || bit_tick === 1'b1) strobes++;
    end
    check("idle_strobes", strobes, 0);
    go();
    push("re_first", 1, 4, 0);
    push("re_mid14", 14, 56, 0);
    push("re_bit16", 1, 4, 1);
    drain("re", 200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/baud_gen_frac.md
# baud_gen_frac

Parametrised fractional baud-rate generator. It is the successor to the fixed-table `baud_rate_gen`. It produces a one-cycle oversample strobe `os_tick` and a one-cycle bit strobe `bit_tick` for the UART transmitter and receiver. The rate comes from a four-entry preset table or from a runtime-loaded integer.fraction divisor. Rate changes apply glitch-free at period boundaries.

## Interface
- `CLK_HZ`, 20_000_000, system clock frequency in Hz, used only for the preset table.
- `OVERSAMPLE`, 16, number of `os_tick` per `bit_tick`; must be ≥2.
- `DIV_W`, 16, integer divisor width.
- `FRAC_W`, 4, fractional divisor width.

Ports:
- `clk`, in, 1: the single clock. Everything is synchronous to `clk`.
- `rst`, in, 1: reset, asynchronous and active-high.
- `en`, in, 1: run enable.
- `rate_sel`, in, 2: preset select. 00 = 9600, 01 = 19200, 10 = 57600, 11 = 115200.
- `use_custom`, in, 1: 1 selects the loaded divisor instead of the preset.
- `div_load`, in, 1: one-cycle strobe that captures `div_int`/`div_frac` into the custom register.
- `div_int`, in, `DIV_W`: integer clocks per `os_tick`.
- `div_frac`, in, `FRAC_W`: fractional part, in units of 1/2^`FRAC_W`.
- `os_tick`, out, 1: oversample strobe.
- `bit_tick`, out, 1: bit strobe, coincident with every `OVERSAMPLE`-th `os_tick`.

## Operation
- Register set: period counter `cnt` (`DIV_W`), fraction accumulator `acc` (`FRAC_W`), oversample counter `os_cnt` (clog2(`OVERSAMPLE`)), custom register, and an active-divisor shadow (int + frac).
- Active divisor source:
  - `use_custom`=1: the custom register.
  - `use_custom`=0: the `rate_sel` preset.
  - The source is sampled into the shadow only at a period boundary (cycle with `os_tick`=1) or when starting from idle.
- Effective integer N = max(shadow int, 2). Values 0 and 1 are clamped to 2.
- Period length is N clocks. If the fraction add at the end of the previous period produced a carry, the length is N+1.
- On each `os_tick`: {carry, `acc`} = `acc` + shadow frac. `os_cnt` increments and wraps at `OVERSAMPLE`-1→0. `bit_tick` asserts in the same cycle as the `os_tick` on which `os_cnt` wraps.
- Average `os_tick` period is N + frac/2^`FRAC_W` clocks.
- Idle (`en`=0):
  - `cnt`, `acc` and `os_cnt` are cleared to 0.
  - Both outputs are 0.
  - `div_load` is still honoured.
- `div_load` while `use_custom`=1 and running: the custom register updates immediately. The shadow picks up the new value at the next boundary, so the current period completes unchanged.
- Simultaneous `div_load` and boundary: the shadow takes the newly loaded value.

## Timing
- Reset values: `os_tick`=0, `bit_tick`=0, `cnt`=0, `acc`=0, `os_cnt`=0, custom int=2, custom frac=0.
- Both outputs are registered and high for exactly one cycle.
- Start-up: `en` sampled high at rising edge E0. The first `os_tick` is high in the cycle after edge E0+N, so N clocks of latency.
- Shadow use at start-up: the first period uses the shadow loaded at E0, with `acc`=0, so there is no extra cycle.
- `en` falling: counting stops at the next edge. An in-flight period is discarded and no strobe is emitted.
- `rst` mid-period: outputs drop asynchronously and the custom register returns to its reset value.

## Configuration
- `BAUD_FRAC_EN` defined: the fractional accumulator is present and behaves as described above.
- `BAUD_FRAC_EN` undefined:
  - `acc` and the frac shadow are not synthesised.
  - `div_frac` is ignored, and the preset table fractions are ignored.
  - Every period is exactly N clocks.
  - Ports are unchanged.

## Structure
- Package `baud_pkg` holds:
  - the rate encodings (`RATE_9600`…`RATE_115200`);
  - the constant baud values;
  - a constant function `baud_div(clk_hz, baud, os, frac_w)` that returns the {int, frac} divisor, with fraction = floor(remainder·2^frac_w / (baud·os)).
- One sub-module: `frac_divider`, containing `cnt`, `acc` and the boundary/shadow logic, and emitting `os_tick`.
- The top level adds preset selection, the custom register and the `os_cnt`/`bit_tick` logic.

## Test plan
- Custom `div_int`=4, `div_frac`=0, `use_custom`=1, `en`=1 → `os_tick` every 4 clocks, `bit_tick` every 64 clocks, and first `os_tick` 4 clocks after `en`.
- `BAUD_FRAC_EN` on, `div_int`=5, `div_frac`=8 → period sequence 5,5,6,5,6,…, and 16 consecutive periods total exactly 88 clocks. With the macro off → every period is 5 clocks.
- Preset `rate_sel`=11 at `CLK_HZ`=20 MHz (divisor 10.85 → int 10, frac 13) → 16 `os_tick` periods total 173 clocks. Switch to `rate_sel`=01 mid-period → the current period completes at old length and the next is 65 clocks (frac 1 carry pattern).
- `div_load` of `div_int`=0 and then `div_int`=1 → periods are 2 clocks each time.
- `rst` asserted mid-period for half a clock cycle → `os_tick` and `bit_tick` fall immediately, and after release the custom divisor reads back as 2.
- `en` dropped mid-period then raised → no strobe while idle, and the first `os_tick` comes N clocks after re-enable with `os_cnt` restarted, so `bit_tick` occurs after 16 `os_tick`.
